// File: rtl/seq_writeback_regfile.sv
// seq_writeback_regfile: write-back stage and architectural register file
// for the SEQ Y86-64 processor. It decodes dstE/dstM from the retiring
// instruction, commits valE/valM on the rising clock edge, and tracks a
// sticky halt state.
// Optional feature: define SEQ_WB_RETIRE_COUNT_EN to add the 64-bit
// retire_count output, which counts committed instructions.
module seq_writeback_regfile #(
  parameter logic [63:0] RSP_INIT = 64'h0000_0000_0000_0200,
  parameter int          NUM_REGS = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [3:0]  icode,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic        cnd,
  input  logic [63:0] valE,
  input  logic [63:0] valM,
  input  logic [1:0]  stat,
  output logic [63:0] rax,
  output logic [63:0] rcx,
  output logic [63:0] rdx,
  output logic [63:0] rbx,
  output logic [63:0] rsp,
  output logic [63:0] rbp,
  output logic [63:0] rsi,
  output logic [63:0] rdi,
  output logic [63:0] r8,
  output logic [63:0] r9,
  output logic [63:0] r10,
  output logic [63:0] r11,
  output logic [63:0] r12,
  output logic [63:0] r13,
  output logic [63:0] r14,
  output logic [3:0]  dstE_q,
  output logic [3:0]  dstM_q,
  output logic        halted,
  output logic [1:0]  halt_code
`ifdef SEQ_WB_RETIRE_COUNT_EN
  ,
  output logic [63:0] retire_count
`endif
);

  localparam logic [3:0] REG_NONE  = 4'hF;
  localparam logic [3:0] REG_RSP   = 4'h4;
  localparam logic [1:0] STAT_AOK  = 2'd0;

  localparam logic [3:0] I_CMOVXX  = 4'h2;
  localparam logic [3:0] I_IRMOVQ  = 4'h3;
  localparam logic [3:0] I_MRMOVQ  = 4'h5;
  localparam logic [3:0] I_OPQ     = 4'h6;
  localparam logic [3:0] I_CALL    = 4'h8;
  localparam logic [3:0] I_RET     = 4'h9;
  localparam logic [3:0] I_PUSHQ   = 4'hA;
  localparam logic [3:0] I_POPQ    = 4'hB;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  state_e      state_r;
  state_e      state_next_s;
  logic        commit_s;
  logic        fault_s;
  logic [3:0]  dst_e_s;
  logic [3:0]  dst_m_s;
  logic [63:0] regs_r [0:NUM_REGS-1];
  logic [3:0]  dst_e_q_r;
  logic [3:0]  dst_m_q_r;
  logic        halted_r;
  logic [1:0]  halt_code_r;

  // Destination decode for the E port (ALU result) and M port (memory result).
  always_comb begin
    dst_e_s = REG_NONE;
    dst_m_s = REG_NONE;
    case (icode)
      I_CMOVXX: begin
        if (cnd) begin
          dst_e_s = rB;
        end else begin
          dst_e_s = REG_NONE;
        end
      end
      I_IRMOVQ, I_OPQ:                  dst_e_s = rB;
      I_CALL, I_RET, I_PUSHQ:           dst_e_s = REG_RSP;
      I_POPQ: begin
        dst_e_s = REG_RSP;
        dst_m_s = rA;
      end
      I_MRMOVQ:                         dst_m_s = rA;
      default: begin
        dst_e_s = REG_NONE;
        dst_m_s = REG_NONE;
      end
    endcase
  end

  // Next-state logic: a valid non-AOK instruction in RUN halts the machine.
  always_comb begin
    state_next_s = state_r;
    commit_s     = 1'b0;
    fault_s      = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (instr_valid) begin
          if (stat == STAT_AOK) begin
            commit_s = 1'b1;
          end else begin
            fault_s      = 1'b1;
            state_next_s = ST_HALTED;
          end
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_HALTED: state_next_s = ST_HALTED;
      default:   state_next_s = ST_RUN;
    endcase
  end

  // State register; only reset leaves HALTED.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Register file commit; the M port is checked first so valM wins on dstE==dstM.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= (4'(i) == REG_RSP) ? RSP_INIT : 64'd0;
      end
    end else if (commit_s) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (dst_m_s == 4'(i)) begin
          regs_r[i] <= valM;
        end else if (dst_e_s == 4'(i)) begin
          regs_r[i] <= valE;
        end
      end
    end
  end

  // Last committed destinations, held across faults and halts.
  always_ff @(posedge clk) begin
    if (reset) begin
      dst_e_q_r <= REG_NONE;
      dst_m_q_r <= REG_NONE;
    end else if (commit_s) begin
      dst_e_q_r <= dst_e_s;
      dst_m_q_r <= dst_m_s;
    end
  end

  // Sticky halt flag and the status code that caused it.
  always_ff @(posedge clk) begin
    if (reset) begin
      halted_r    <= 1'b0;
      halt_code_r <= 2'd0;
    end else if (fault_s) begin
      halted_r    <= 1'b1;
      halt_code_r <= stat;
    end
  end

`ifdef SEQ_WB_RETIRE_COUNT_EN
  logic [63:0] retire_count_r;

  // Count committed instructions, wrapping naturally at 2^64.
  always_ff @(posedge clk) begin
    if (reset) begin
      retire_count_r <= 64'd0;
    end else if (commit_s) begin
      retire_count_r <= retire_count_r + 64'd1;
    end
  end

  assign retire_count = retire_count_r;
`endif

  assign rax       = regs_r[0];
  assign rcx       = regs_r[1];
  assign rdx       = regs_r[2];
  assign rbx       = regs_r[3];
  assign rsp       = regs_r[4];
  assign rbp       = regs_r[5];
  assign rsi       = regs_r[6];
  assign rdi       = regs_r[7];
  assign r8        = regs_r[8];
  assign r9        = regs_r[9];
  assign r10       = regs_r[10];
  assign r11       = regs_r[11];
  assign r12       = regs_r[12];
  assign r13       = regs_r[13];
  assign r14       = regs_r[14];
  assign dstE_q    = dst_e_q_r;
  assign dstM_q    = dst_m_q_r;
  assign halted    = halted_r;
  assign halt_code = halt_code_r;

endmodule

// File: tb/tb_seq_writeback_regfile.sv
// Scoreboard testbench for seq_writeback_regfile: a driver applies directed
// and random instructions and pushes the expected architectural state into
// a queue; a monitor pops and compares one entry after every clock edge.
module tb_seq_writeback_regfile;

  localparam logic [63:0] RSP_INIT = 64'h0000_0000_0000_0200;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid = 1'b0;
  logic [3:0]  icode = 4'h0;
  logic [3:0]  rA = 4'hF;
  logic [3:0]  rB = 4'hF;
  logic        cnd = 1'b0;
  logic [63:0] valE = 64'd0;
  logic [63:0] valM = 64'd0;
  logic [1:0]  stat = 2'd0;
  logic [63:0] dr [15];
  logic [3:0]  dstE_q, dstM_q;
  logic        halted;
  logic [1:0]  halt_code;
`ifdef SEQ_WB_RETIRE_COUNT_EN
  logic [63:0] retire_count;
`endif

  seq_writeback_regfile #(.RSP_INIT(RSP_INIT), .NUM_REGS(15)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .icode(icode),
    .rA(rA), .rB(rB), .cnd(cnd), .valE(valE), .valM(valM), .stat(stat),
    .rax(dr[0]), .rcx(dr[1]), .rdx(dr[2]), .rbx(dr[3]), .rsp(dr[4]),
    .rbp(dr[5]), .rsi(dr[6]), .rdi(dr[7]), .r8(dr[8]), .r9(dr[9]),
    .r10(dr[10]), .r11(dr[11]), .r12(dr[12]), .r13(dr[13]), .r14(dr[14]),
    .dstE_q(dstE_q), .dstM_q(dstM_q), .halted(halted), .halt_code(halt_code)
`ifdef SEQ_WB_RETIRE_COUNT_EN
    , .retire_count(retire_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [14:0][63:0] regs;
    logic [3:0]        de;
    logic [3:0]        dm;
    logic              h;
    logic [1:0]        hc;
    logic [63:0]       cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;

  // Reference architectural state
  logic [63:0] m_regs [15];
  logic [3:0]  m_de = 4'hF, m_dm = 4'hF;
  logic        m_h = 1'b0;
  logic [1:0]  m_hc = 2'd0;
  logic [63:0] m_cnt = 64'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic push_exp();
    exp_t e;
    for (int i = 0; i < 15; i++) e.regs[i] = m_regs[i];
    e.de = m_de; e.dm = m_dm; e.h = m_h; e.hc = m_hc; e.cnt = m_cnt;
    exp_q.push_back(e);
  endtask

  // Architectural effect of one clock edge, straight from the ISA rules.
  task automatic model(input logic r, input logic v, input logic [3:0] ic,
                       input logic [3:0] ra, input logic [3:0] rb, input logic c,
                       input logic [63:0] ve, input logic [63:0] vm, input logic [1:0] st);
    logic [3:0] de, dm;
    if (r) begin
      for (int i = 0; i < 15; i++) m_regs[i] = 64'd0;
      m_regs[4] = RSP_INIT;
      m_de = 4'hF; m_dm = 4'hF; m_h = 1'b0; m_hc = 2'd0; m_cnt = 64'd0;
    end else if (!m_h && v) begin
      if (st == 2'd0) begin
        de = 4'hF; dm = 4'hF;
        if (ic == 4'h3 || ic == 4'h6 || (ic == 4'h2 && c)) de = rb;
        if (ic == 4'h8 || ic == 4'h9 || ic == 4'hA || ic == 4'hB) de = 4'h4;
        if (ic == 4'h5 || ic == 4'hB) dm = ra;
        if (de != 4'hF) m_regs[de] = ve;
        if (dm != 4'hF) m_regs[dm] = vm;
        m_de = de; m_dm = dm;
        m_cnt = m_cnt + 64'd1;
      end else begin
        m_h = 1'b1; m_hc = st;
      end
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [3:0] ic,
                      input logic [3:0] ra, input logic [3:0] rb, input logic c,
                      input logic [63:0] ve, input logic [63:0] vm, input logic [1:0] st);
    @(negedge clk);
    reset = r; instr_valid = v; icode = ic; rA = ra; rB = rb; cnd = c;
    valE = ve; valM = vm; stat = st;
    model(r, v, ic, ra, rb, c, ve, vm, st);
    push_exp();
  endtask

  // Monitor: compare the DUT against the oldest expectation after each edge.
  exp_t mon_e;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      for (int i = 0; i < 15; i++) chk($sformatf("reg%0d", i), dr[i], mon_e.regs[i]);
      chk("dstE_q", 64'(dstE_q), 64'(mon_e.de));
      chk("dstM_q", 64'(dstM_q), 64'(mon_e.dm));
      chk("halted", 64'(halted), 64'(mon_e.h));
      chk("halt_code", 64'(halt_code), 64'(mon_e.hc));
`ifdef SEQ_WB_RETIRE_COUNT_EN
      chk("retire_count", retire_count, mon_e.cnt);
`endif
    end
  end

  initial begin
    for (int i = 0; i < 15; i++) m_regs[i] = 64'd0;
    // Reset state
    step(1'b1, 1'b0, 4'h0, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 2'd0);
    // irmovq into rdx
    step(1'b0, 1'b1, 4'h3, 4'hF, 4'h2, 1'b0, 64'h1234, 64'd0, 2'd0);
    // cmovXX not taken, then taken
    step(1'b0, 1'b1, 4'h2, 4'h1, 4'h3, 1'b0, 64'h55, 64'd0, 2'd0);
    step(1'b0, 1'b1, 4'h2, 4'h1, 4'h3, 1'b1, 64'h55, 64'd0, 2'd0);
    // popq %rsp: valM wins; then pushq
    step(1'b0, 1'b1, 4'hB, 4'h4, 4'hF, 1'b0, 64'h208, 64'hABCD, 2'd0);
    step(1'b0, 1'b1, 4'hA, 4'h1, 4'hF, 1'b0, 64'h1F8, 64'd0, 2'd0);
    // irmovq with rB=F writes nothing
    step(1'b0, 1'b1, 4'h3, 4'hF, 4'hF, 1'b0, 64'h9999, 64'd0, 2'd0);
    // Idle cycle
    step(1'b0, 1'b0, 4'h3, 4'hF, 4'h1, 1'b0, 64'h7777, 64'd0, 2'd0);
    // ADR fault, then ignored commits while halted
    step(1'b0, 1'b1, 4'h6, 4'hF, 4'h0, 1'b0, 64'd7, 64'd0, 2'd2);
    step(1'b0, 1'b1, 4'h3, 4'hF, 4'h1, 1'b0, 64'h42, 64'd0, 2'd0);
    step(1'b0, 1'b1, 4'h1, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 2'd3);
    // Reset from HALTED, with a concurrent write that must be overridden
    step(1'b1, 1'b1, 4'h3, 4'hF, 4'h4, 1'b0, 64'h5555, 64'd0, 2'd0);
    // Retire counting: nop, irmovq, rmmovq, idle
    step(1'b0, 1'b1, 4'h1, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 2'd0);
    step(1'b0, 1'b1, 4'h3, 4'hF, 4'h5, 1'b0, 64'hAA, 64'd0, 2'd0);
    step(1'b0, 1'b1, 4'h4, 4'h5, 4'h4, 1'b0, 64'h300, 64'd0, 2'd0);
    step(1'b0, 1'b0, 4'h0, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 2'd0);
`ifdef SEQ_WB_RETIRE_COUNT_EN
    // Counter wrap from all-ones
    @(negedge clk);
    reset = 1'b0; instr_valid = 1'b0;
    dut.retire_count_r = 64'hFFFF_FFFF_FFFF_FFFF;
    m_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    push_exp();
    step(1'b0, 1'b1, 4'h1, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 2'd0);
`endif
    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      step(($urandom_range(0, 59) == 0),
           ($urandom_range(0, 3) != 0),
           4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)),
           {$urandom, $urandom},
           {$urandom, $urandom},
           ($urandom_range(0, 39) == 0) ? 2'($urandom_range(1, 3)) : 2'd0);
    end
    step(1'b0, 1'b0, 4'h0, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 2'd0);
    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_writeback_regfile.md
Name: seq_writeback_regfile

Overview:
- Write-back stage and architectural register file for the SEQ Y86-64 processor.
- Derives dstE/dstM from the retiring instruction's icode/rA/rB/Cnd and commits valE/valM on the clock edge.
- Drives the 15 flat register buses (rax..r14) consumed by the decode stage.
- Tracks processor status with a sticky halt state machine.

Parameters:
- RSP_INIT, 64'h0000_0000_0000_0200, reset value of rsp (register 4); all other registers reset to 0.
- NUM_REGS, 15, architectural registers; index 4'hF means "no register".

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- instr_valid  input  1  a retiring instruction is presented this cycle.
- icode  input  4  instruction code of the retiring instruction.
- rA  input  4  rA field.
- rB  input  4  rB field.
- cnd  input  1  condition result from execute (used by cmovXX).
- valE  input  64  execute result.
- valM  input  64  memory read result.
- stat  input  2  status of the retiring instruction: 0 AOK, 1 HLT, 2 ADR, 3 INS.
- rax, rcx, rdx, rbx, rsp, rbp, rsi, rdi, r8, r9, r10, r11, r12, r13, r14  output  64 each  current register contents, driven directly from flops.
- dstE_q  output  4  dstE of the last committed instruction (4'hF if none).
- dstM_q  output  4  dstM of the last committed instruction (4'hF if none).
- halted  output  1  high in HALTED state.
- halt_code  output  2  stat value that caused the halt.

Behaviour:
- Reset (sync, clk edge with reset=1), state after reset:
  - rsp=RSP_INIT; all other registers=0.
  - dstE_q=dstM_q=4'hF; halted=0; halt_code=0; state RUN.
  - Reset overrides any concurrent write.
  - Reset asserted while HALTED returns to RUN.
- dstE decode (combinational):
  - icode 2 → rB if cnd=1, else F.
  - icode 3 or 6 → rB.
  - icode 8, 9, A, B → 4.
  - All other icodes → F.
- dstM decode (combinational):
  - icode 5 or B → rA.
  - All other icodes → F.
- FSM states: RUN, HALTED.
- RUN with instr_valid=1 and stat=AOK (commit):
  - If dstE≠F: reg[dstE] ← valE.
  - If dstM≠F: reg[dstM] ← valM.
  - dstE_q/dstM_q updated.
  - Stay in RUN.
- RUN with instr_valid=1 and stat≠AOK:
  - No register writes; dstE_q/dstM_q unchanged.
  - halt_code←stat; halted←1; go to HALTED.
- RUN with instr_valid=0: no change.
- HALTED: all inputs ignored; registers frozen; leave only via reset.
- Conflict rule: dstE==dstM (e.g. popq %rsp) → valM wins; reg gets valM.
- Latency:
  - Write visible on register outputs the cycle after the commit edge.
  - No internal bypass; same-cycle reads see old values.
- rA/rB = F on an instruction that selects them → no write on that port.
- Writes are full 64-bit; no partial updates.

Optional Feature:
- Macro: SEQ_WB_RETIRE_COUNT_EN.
- Defined:
  - Adds output retire_count [63:0], reset to 0.
  - Increments by 1 on every commit (RUN, instr_valid, stat=AOK), including instructions with no destination (nop, jXX, rmmovq).
  - Wraps from 2^64-1 to 0.
  - Frozen in HALTED.
- Undefined: port absent, no counter logic.

Test Plan:
1. Reset → rsp=64'h200, rax..r14 others=0, halted=0, dstE_q=dstM_q=F.
2. irmovq (icode 3, rB=2, valE=64'h1234, AOK) → rdx=64'h1234 next cycle; dstE_q=2, dstM_q=F.
3. cmovXX (icode 2, rB=3, valE=64'h55):
   - cnd=0 → rbx unchanged, dstE_q=F.
   - cnd=1 → rbx=64'h55.
4. popq %rsp (icode B, rA=4, valE=64'h208, valM=64'hABCD, AOK) → rsp=64'hABCD. pushq (icode A, valE=64'h1F8) → rsp=64'h1F8.
5. Halt sequence:
   - instr_valid=1, stat=2 (ADR), icode 6, rB=0, valE=7 → rax unchanged, halted=1, halt_code=2.
   - Later irmovq with stat=AOK → no change.
   - Reset → RUN, registers at reset values.
6. With SEQ_WB_RETIRE_COUNT_EN:
   - 3 AOK commits (nop, irmovq, rmmovq) plus 1 idle cycle → retire_count=3.
   - Force count 64'hFFFF_FFFF_FFFF_FFFF, one commit → 0.
